aoi_nm_pipe: RTL and testbench
==============================

Name: aoi_nm_pipe

Overview:
- Parametrised, pipelined successor to the fixed AOI221 cell.
- Each of WIDTH lanes computes a configurable AND-OR-INVERT (or OR-AND-INVERT) over one direct input and NGRP groups of GW inputs.
- Operands travel through a 2-stage valid/ready pipeline.
- Used as a registered wide logic-reduction primitive in datapath glue, where combinational AOI chains would break timing.

Parameters:
WIDTH, 8, number of independent bit lanes
NGRP, 2, number of AND (or OR) groups per lane, >=1
GW, 2, inputs per group, >=2

Ports:
CK  input  1  clock, rising edge
RST  input  1  asynchronous active-high reset
in_valid  input  1  operand valid
in_ready  output  1  pipeline can accept operand this cycle
MODE  input  1  0 = AOI, 1 = OAI; captured with operand
A  input  WIDTH  direct input per lane
B  input  NGRP*GW*WIDTH  group inputs; bit for group g, input i, lane l at index (g*GW+i)*WIDTH+l
out_valid  output  1  ZN holds a valid result
out_ready  input  1  consumer accepts ZN
ZN  output  WIDTH  registered result

Behaviour:
- Reset (async assert, sync release on CK): s1_valid=0, s2_valid=0, out_valid=0, ZN=0, all operand registers 0, in_ready=1 after reset.
- Function per lane l:
  - AOI: ZN[l] = ~(A[l] | OR over g of (AND over i of B[g,i,l])).
  - OAI: ZN[l] = ~(A[l] & AND over g of (OR over i of B[g,i,l])).
- Stage 1 (S1): registers A, B, MODE when in_valid && in_ready.
- Function evaluation: combinational on S1 outputs.
- Stage 2 (S2): registers the result into ZN.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_adv.
  - in_ready = !s1_valid || s2_adv (combinational from out_ready; no combinational in_valid->in_ready path).
- Latency: operand accepted at edge k appears on ZN with out_valid=1 after edge k+1, given no backpressure. Throughput 1 result per cycle.
- Backpressure:
  - out_valid && !out_ready: ZN and S2 hold stable.
  - S1 holds if full; in_ready drops only when both stages are full.
- Simultaneous accept and drain in the same cycle: both occur, with no bubble inserted and no data lost.
- out_valid never drops without a handshake. ZN is stable while out_valid && !out_ready.
- MODE is sampled per operand, so mixed-mode back-to-back operands are legal.
- RST mid-operation: both stages empty immediately; in-flight data discarded; out_valid=0 asynchronously.
- Result width is WIDTH; no arithmetic carries.

Optional Feature:
- AOI_PIPE_MASK_EN defined:
  - Adds input GMASK [NGRP], captured into S1 with the operand.
  - A group g with GMASK[g]=0 is forced neutral: its term is 0 in AOI mode and 1 in OAI mode.
  - All-zero GMASK reduces the function to ZN = ~A in both modes.
- Macro undefined: no GMASK port; all groups are always active.

Decomposition:
- Package aoi_nm_pkg: mode_e enum (MODE_AOI=1'b0, MODE_OAI=1'b1); localparam helper function for the B bit index.
- Sub-module aoi_nm_lane: purely combinational single-lane function (A, group bits, MODE, optional mask -> zn). Instantiated WIDTH times in a generate loop between S1 and S2.

Test Plan:
- Reset/idle: assert RST mid-stream with both stages full -> out_valid=0, ZN=8'h00, in_ready=1 same cycle; no stale result after release.
- AOI basic: MODE=0, A=8'h01, B=0, out_ready=1 -> two cycles later ZN=8'hFE. Then B group0 inputs both 8'h30 -> ZN=8'hCF.
- OAI basic: MODE=0->1, A=8'hFF, group0 input0=8'hFF, group1 input1=8'h0F, rest 0 -> ZN=8'hF0.
- Streaming: 16 back-to-back operands with random MODE, out_ready=1 -> 16 results in order, one per cycle, first two cycles after first accept; in_ready constantly 1.
- Backpressure: hold out_ready=0 for 5 cycles while in_valid=1 -> exactly two operands accepted, in_ready=0 thereafter, ZN stable. Release -> results drained in order with no loss or duplication.
- Mask (AOI_PIPE_MASK_EN): GMASK=2'b00, A=8'h0F, B all ones, MODE=0 -> ZN=8'hF0. GMASK=2'b01 -> ZN=8'h00.

Source files
------------

// File: rtl/aoi_nm_pkg.sv
// Shared types and helpers for the pipelined AOI/OAI reduction block.
// The optional group mask is enabled with the AOI_PIPE_MASK_EN macro.
package aoi_nm_pkg;

  typedef enum logic {
    MODE_AOI = 1'b0,
    MODE_OAI = 1'b1
  } mode_e;

  // Flat position of group g, input i, lane l inside the packed B bus
  function automatic int unsigned b_index(input int unsigned g, input int unsigned i,
                                          input int unsigned l, input int unsigned gw,
                                          input int unsigned width);
    return (g * gw + i) * width + l;
  endfunction

endpackage

// File: rtl/aoi_nm_lane.sv
// Combinational single-lane AOI/OAI over one direct input and NGRP groups of GW bits.
// With AOI_PIPE_MASK_EN defined, a gmask input can neutralise individual groups.
module aoi_nm_lane
  import aoi_nm_pkg::*;
#(
  parameter int NGRP = 2,
  parameter int GW   = 2
) (
  input  logic               a,
  input  logic [NGRP*GW-1:0] grp,
  input  mode_e              mode,
`ifdef AOI_PIPE_MASK_EN
  input  logic [NGRP-1:0]    gmask,
`endif
  output logic               zn
);

  logic or_acc_s;
  logic and_acc_s;

  // A masked group contributes the identity of the outer reduction: 0 for OR, 1 for AND
  always_comb begin
    or_acc_s  = 1'b0;
    and_acc_s = 1'b1;
    for (int g = 0; g < NGRP; g++) begin
`ifdef AOI_PIPE_MASK_EN
      or_acc_s  = or_acc_s  | (gmask[g] & (&grp[g*GW +: GW]));
      and_acc_s = and_acc_s & (~gmask[g] | (|grp[g*GW +: GW]));
`else
      or_acc_s  = or_acc_s  | (&grp[g*GW +: GW]);
      and_acc_s = and_acc_s & (|grp[g*GW +: GW]);
`endif
    end
    zn = 1'b0;
    case (mode)
      MODE_AOI: zn = ~(a | or_acc_s);
      MODE_OAI: zn = ~(a & and_acc_s);
      default:  zn = 1'b0;
    endcase
  end

endmodule

// File: rtl/aoi_nm_pipe.sv
// Two-stage valid/ready pipelined AOI/OAI reduction across WIDTH independent lanes.
// Defining AOI_PIPE_MASK_EN adds a per-group GMASK input captured with each operand.
module aoi_nm_pipe
  import aoi_nm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NGRP  = 2,
  parameter int GW    = 2
) (
  input  logic                    CK,
  input  logic                    RST,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    MODE,
  input  logic [WIDTH-1:0]        A,
  input  logic [NGRP*GW*WIDTH-1:0] B,
`ifdef AOI_PIPE_MASK_EN
  input  logic [NGRP-1:0]         GMASK,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        ZN
);

  logic                     s1_valid_r;
  logic [WIDTH-1:0]         a_r;
  logic [NGRP*GW*WIDTH-1:0] b_r;
  mode_e                    mode_r;
`ifdef AOI_PIPE_MASK_EN
  logic [NGRP-1:0]          gmask_r;
`endif
  logic                     s2_valid_r;
  logic [WIDTH-1:0]         zn_r;

  logic                     s2_adv_s;
  logic                     s1_adv_s;
  logic                     accept_s;
  logic [WIDTH-1:0]         zn_s;

  assign s2_adv_s  = !s2_valid_r || out_ready;
  assign s1_adv_s  = s1_valid_r && s2_adv_s;
  assign in_ready  = !s1_valid_r || s2_adv_s;
  assign accept_s  = in_valid && in_ready;
  assign out_valid = s2_valid_r;
  assign ZN        = zn_r;

  // Stage 1: capture operand; a same-cycle accept keeps the stage full with new data
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      s1_valid_r <= 1'b0;
      a_r        <= {WIDTH{1'b0}};
      b_r        <= {(NGRP*GW*WIDTH){1'b0}};
      mode_r     <= MODE_AOI;
`ifdef AOI_PIPE_MASK_EN
      gmask_r    <= {NGRP{1'b0}};
`endif
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      a_r        <= A;
      b_r        <= B;
      mode_r     <= mode_e'(MODE);
`ifdef AOI_PIPE_MASK_EN
      gmask_r    <= GMASK;
`endif
    end else if (s1_adv_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  for (genvar l = 0; l < WIDTH; l++) begin : g_lane
    logic [NGRP*GW-1:0] lane_grp_s;
    for (genvar g = 0; g < NGRP; g++) begin : g_grp
      for (genvar i = 0; i < GW; i++) begin : g_in
        assign lane_grp_s[g*GW+i] = b_r[b_index(g, i, l, GW, WIDTH)];
      end
    end
    aoi_nm_lane #(
      .NGRP (NGRP),
      .GW   (GW)
    ) u_lane (
      .a     (a_r[l]),
      .grp   (lane_grp_s),
      .mode  (mode_r),
`ifdef AOI_PIPE_MASK_EN
      .gmask (gmask_r),
`endif
      .zn    (zn_s[l])
    );
  end

  // Stage 2: result register, frozen while the consumer stalls
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      s2_valid_r <= 1'b0;
      zn_r       <= {WIDTH{1'b0}};
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        zn_r <= zn_s;
      end
    end
  end

endmodule

// File: tb/tb_aoi_nm_pipe.sv
// Directed self-checking bench for aoi_nm_pipe (WIDTH=8, NGRP=2, GW=2).
// Mask vectors are exercised only when AOI_PIPE_MASK_EN is defined.
module tb_aoi_nm_pipe;

  logic        CK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic        MODE;
  logic [7:0]  A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  ZN;
`ifdef AOI_PIPE_MASK_EN
  logic [1:0]  gmask;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CK = ~CK;

  aoi_nm_pipe #(
    .WIDTH (8),
    .NGRP  (2),
    .GW    (2)
  ) dut (
    .CK        (CK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .MODE      (MODE),
    .A         (A),
    .B         (B),
`ifdef AOI_PIPE_MASK_EN
    .GMASK     (gmask),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ZN        (ZN)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // B byte k holds group k/2, input k%2 for all eight lanes
  function automatic logic [7:0] model(input logic m, input logic [7:0] a, input logic [31:0] b);
    if (m)
      return ~(a & (b[7:0] | b[15:8]) & (b[23:16] | b[31:24]));
    else
      return ~(a | (b[7:0] & b[15:8]) | (b[23:16] & b[31:24]));
  endfunction

  task automatic single(input logic m, input logic [7:0] a, input logic [31:0] b,
                        input logic [7:0] exp, input string tag);
    @(negedge CK);
    MODE = m; A = a; B = b; in_valid = 1'b1;
    @(negedge CK);
    in_valid = 1'b0;
    @(negedge CK);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check(tag, 32'(ZN), 32'(exp));
  endtask

  logic        m_v [16];
  logic [7:0]  a_v [16];
  logic [31:0] b_v [16];
  logic [7:0]  e_v [16];
  logic [15:0] mbits;
  logic        bm [3];
  logic [7:0]  ba [3];
  logic [31:0] bb [3];
  int          acc;

  initial begin
    RST = 1'b1; in_valid = 1'b0; MODE = 1'b0; A = 8'h00; B = 32'h0; out_ready = 1'b0;
`ifdef AOI_PIPE_MASK_EN
    gmask = 2'b11;
`endif
    repeat (2) @(negedge CK);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_zn", 32'(ZN), 32'h00);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    RST = 1'b0;
    out_ready = 1'b1;

    single(1'b0, 8'h01, 32'h0000_0000, 8'hFE, "aoi_b0");
    single(1'b0, 8'h00, 32'h0000_3030, 8'hCF, "aoi_g0");
    single(1'b1, 8'hFF, 32'h0F00_00FF, 8'hF0, "oai_basic");

    // streaming: 16 back-to-back operands with mixed modes
    mbits = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      m_v[i] = mbits[i];
      a_v[i] = 8'(i * 37 + 5);
      b_v[i] = {8'(i * 13), 8'(~i * 7), 8'(i * 91 + 3), 8'(i ^ 8'h5A)};
      e_v[i] = model(m_v[i], a_v[i], b_v[i]);
    end
    for (int i = 0; i < 19; i++) begin
      @(negedge CK);
      check("stream_out_valid", 32'(out_valid), (i >= 2 && i < 18) ? 32'd1 : 32'd0);
      if (i >= 2 && i < 18) check("stream_zn", 32'(ZN), 32'(e_v[i-2]));
      if (i < 16) begin
        check("stream_in_ready", 32'(in_ready), 32'd1);
        MODE = m_v[i]; A = a_v[i]; B = b_v[i]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end

    // backpressure: consumer stalls while the producer keeps offering operands
    bm[0] = 1'b0; ba[0] = 8'h80; bb[0] = 32'h0C0A_0301;
    bm[1] = 1'b1; ba[1] = 8'h07; bb[1] = 32'h0F44_2211;
    bm[2] = 1'b0; ba[2] = 8'h00; bb[2] = 32'h0000_0000;
    out_ready = 1'b0;
    acc = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge CK);
      if (j >= 2) begin
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_zn_hold", 32'(ZN), 32'h76);
      end
      MODE = bm[acc]; A = ba[acc]; B = bb[acc]; in_valid = 1'b1;
      if (in_ready) acc++;
    end
    check("bp_accepted", 32'(acc), 32'd2);
    @(negedge CK);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("bp_rel_in_ready", 32'(in_ready), 32'd1);
    check("bp_drain0_valid", 32'(out_valid), 32'd1);
    check("bp_drain0_zn", 32'(ZN), 32'h76);
    @(negedge CK);
    check("bp_drain1_valid", 32'(out_valid), 32'd1);
    check("bp_drain1_zn", 32'(ZN), 32'hFC);
    @(negedge CK);
    check("bp_drained", 32'(out_valid), 32'd0);

    // reset with both stages full
    out_ready = 1'b0;
    @(negedge CK);
    MODE = 1'b0; A = 8'h00; B = 32'h0; in_valid = 1'b1;
    @(negedge CK);
    MODE = 1'b1; A = 8'hFF; B = 32'hFFFF_FFFF;
    @(negedge CK);
    in_valid = 1'b0;
    check("full_out_valid", 32'(out_valid), 32'd1);
    check("full_in_ready", 32'(in_ready), 32'd0);
    RST = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_zn", 32'(ZN), 32'h00);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge CK);
    RST = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge CK);
    check("post_rst_no_stale", 32'(out_valid), 32'd0);

`ifdef AOI_PIPE_MASK_EN
    gmask = 2'b00;
    single(1'b0, 8'h0F, 32'hFFFF_FFFF, 8'hF0, "mask00_aoi");
    single(1'b1, 8'h0F, 32'h0000_0000, 8'hF0, "mask00_oai");
    gmask = 2'b01;
    single(1'b0, 8'h0F, 32'hFFFF_FFFF, 8'h00, "mask01_aoi");
    gmask = 2'b11;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
